// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: walks V elements through a single-element memory port,
// one element per granted cycle, and assembles load data into a V x N vector.
`timescale 1ns/1ps
module vec_mem_seq #(
  parameter int N = 32,
  parameter int V = 20
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start_i,
  input  logic                is_store_i,
  input  logic [N-1:0]        base_addr_i,
  input  logic [V-1:0][N-1:0] store_data_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [N-1:0]        mem_addr_o,
  output logic [N-1:0]        mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic [N-1:0]        mem_rdata_i,
  output logic                stall_o,
  output logic                done_o,
  output logic [V-1:0][N-1:0] load_data_o
);

  localparam int            IW   = (V > 1) ? $clog2(V) : 1;
  localparam logic [IW-1:0] LAST = IW'(V - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_d;
  logic [IW-1:0]       rd_idx_q;
  logic                is_store_q;
  logic                rd_pend_q;
  logic [N-1:0]        base_q;
  logic [V-1:0][N-1:0] sdata_q;
  logic [V-1:0][N-1:0] load_q;
  logic                take;

  assign take  = (state_q == IDLE) && start_i;
  assign idx_d = idx_q + IW'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_idx_q   <= '0;
      is_store_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      load_q     <= '0;
    end else begin
      // A read accepted last cycle returns now; in ISSUE this overlaps the next request.
      rd_pend_q <= 1'b0;
      if (rd_pend_q) begin
        load_q[rd_idx_q] <= mem_rdata_i;
      end
      case (state_q)
        IDLE: begin
          if (start_i) begin
            is_store_q <= is_store_i;
            idx_q      <= '0;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_gnt_i) begin
            rd_pend_q <= ~is_store_q;
            rd_idx_q  <= idx_q;
            if (idx_q == LAST) begin
              state_q <= is_store_q ? DONE : DRAIN;
            end else begin
              idx_q <= idx_d;
            end
          end
        end
        DRAIN:   state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand capture needs no reset: it is only observed after a start latches it.
  always_ff @(posedge CLK) begin
    if (take) begin
      base_q  <= base_addr_i;
      sdata_q <= store_data_i;
    end
  end

  always_comb begin
    mem_req_o   = (state_q == ISSUE);
    mem_we_o    = mem_req_o && is_store_q;
    mem_addr_o  = mem_req_o ? (base_q + (N'(idx_q) << 2)) : '0;
    mem_wdata_o = mem_we_o ? sdata_q[idx_q] : '0;
  end

  assign stall_o     = (state_q == ISSUE) || (state_q == DRAIN) ||
                       ((state_q == IDLE) && start_i && !RST);
  assign done_o      = (state_q == DONE);
  assign load_data_o = load_q;

endmodule

// File: doc/vec_mem_seq.md
VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, scalar element width in bits.
REQ-002 The block SHALL have parameter V, default 20, elements per vector.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port start_i  input  1  vector memory op request from MEM stage.
REQ-006 The block SHALL have port is_store_i  input  1  1 = vector store, 0 = vector load; sampled with start_i.
REQ-007 The block SHALL have port base_addr_i  input  N  byte address of element 0; sampled with start_i.
REQ-008 The block SHALL have port store_data_i  input  V x N  store vector; sampled with start_i.
REQ-009 The block SHALL have port mem_req_o  output  1  element access request.
REQ-010 The block SHALL have port mem_we_o  output  1  write enable for the current request.
REQ-011 The block SHALL have port mem_addr_o  output  N  element byte address.
REQ-012 The block SHALL have port mem_wdata_o  output  N  element write data.
REQ-013 The block SHALL have port mem_gnt_i  input  1  memory accepts the request this cycle.
REQ-014 The block SHALL have port mem_rdata_i  input  N  read data, valid the cycle after an accepted read.
REQ-015 The block SHALL have port stall_o  output  1  freeze pipeline registers (pipeline enable_i = ~stall_o).
REQ-016 The block SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-017 The block SHALL have port load_data_o  output  V x N  assembled load vector.

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE, DRAIN, DONE.
REQ-019 IDLE with start_i=1 SHALL latch is_store_i, base_addr_i and store_data_i, clear the element index to 0, and go to ISSUE; start_i SHALL be ignored in every other state.
REQ-020 In ISSUE: mem_req_o=1, mem_we_o=latched is_store, mem_addr_o=base+4*idx (mod 2^N, wrap-around allowed), mem_wdata_o=store element idx (0 for loads).
REQ-021 With mem_gnt_i=0, all mem_* outputs SHALL hold stable and idx SHALL NOT advance.
REQ-022 With mem_gnt_i=1 and idx<V-1, idx SHALL increment by 1; with idx=V-1, a load SHALL go to DRAIN and a store to DONE.
REQ-023 For each read accepted at index k, mem_rdata_i on the next cycle SHALL be written to load_data_o element k; in ISSUE this capture SHALL overlap the next request.
REQ-024 DRAIN SHALL capture element V-1 and go to DONE after exactly one cycle; mem_req_o=0 in DRAIN.
REQ-025 DONE SHALL assert done_o=1 for exactly one cycle, then go to IDLE.
REQ-026 stall_o SHALL be combinational: 1 in ISSUE and DRAIN, and 1 in IDLE when start_i=1; 0 in DONE and in idle IDLE.
REQ-027 With continuous grant, a load SHALL take V+2 cycles from the start edge to the done_o cycle inclusive, and a store V+1.
REQ-028 load_data_o SHALL hold its value from done until the next load writes it; stores SHALL NOT modify it.
REQ-029 mem_req_o SHALL be 0 in IDLE, DRAIN and DONE.

Reset
REQ-030 With RST=1 at a rising edge, the FSM SHALL enter IDLE, clear idx, and clear load_data_o to all zeros; mem_req_o, mem_we_o, done_o and stall_o SHALL be 0 the following cycle.
REQ-031 RST SHALL take priority over start_i and abort any operation in progress, with no done_o pulse and no further mem_req_o.

Verification
REQ-032 Reset with start_i=1 -> IDLE, all outputs 0, load_data_o all zero.
REQ-033 Load at base 0x100, gnt always 1, memory returns addr/4 -> addresses 0x100..0x14C, load_data_o[k]=0x40+k, done_o at cycle V+2, stall_o high until done.
REQ-034 Store at base 0x200, store_data[k]=k+1, gnt low for 3 cycles at idx 5 -> idx 5 request held 3 extra cycles, 20 writes total, done_o at cycle V+4, load_data_o unchanged.
REQ-035 Load at base 0xFFFFFFF8 -> addresses wrap to 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, ...
REQ-036 RST asserted at idx 7 of a load -> next cycle IDLE, mem_req_o=0, no done_o pulse; a new start then runs from idx 0.
REQ-037 start_i held high through an entire operation -> only one operation runs; a second start is taken only in IDLE after DONE.
